// File: rtl/ip2_scan_out_capture_if.sv
// Word stream from the scan_out capture block to the readout FIFO.
// Valid/ready handshake; the producer holds data stable while valid and not ready.
interface ip2_scan_out_capture_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ip2_scan_out_capture.sv
// Captures scan_out serially on clk_counter strobes, packs WORD_W-bit words (bit 0 first).
// Word visible the edge after its final bit; a load against a stalled word is dropped and flagged.
module ip2_scan_out_capture #(
  parameter int WORD_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_not,
  input  logic                          enable,
  input  logic [5:0]                    clk_counter,
  input  logic [5:0]                    test_sample_phase,
  input  logic                          test_start_re,
  input  logic                          scan_load,
  input  logic                          scan_out,
  input  logic [9:0]                    bit_cnt_max,
  ip2_scan_out_capture_if.master        word_if,
  output logic [9:0]                    bit_cnt,
  output logic                          status_busy,
  output logic                          status_done,
  output logic                          status_abort,
  output logic                          status_overflow,
  output logic [1:0]                    state
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SHIFT = 2'd1,
    CAPTURE    = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [9:0]               bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
  logic [WORD_W-1:0]        shreg_q, shreg_d;
  logic [WORD_W-1:0]        word_data_q, word_data_d;
  logic                     word_valid_q, word_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     abort_q, abort_d;
  logic                     ovf_q, ovf_d;

  logic                     scan_out_s;
  logic                     strobe;
  logic                     xfer;
  logic                     word_load;
  logic                     final_bit;
  logic [WORD_W-1:0]        new_word;
  logic [WORD_W-1:0]        capt_word;

  assign scan_out_s = sync_q[SYNC_STAGES-1];
  assign strobe     = (clk_counter == test_sample_phase);
  assign xfer       = word_valid_q & word_if.word_ready;
  assign capt_word  = shreg_q | (WORD_W'(scan_out_s) << bit_idx_q);

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[SYNC_STAGES-2:0], scan_out};
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q & ~xfer;
    busy_d       = busy_q;
    done_d       = done_q;
    abort_d      = abort_q;
    ovf_d        = ovf_q;
    word_load    = 1'b0;
    final_bit    = 1'b0;
    new_word     = '0;

    case (state_q)
      IDLE, DONE: begin
        if (test_start_re) begin
          state_d   = WAIT_SHIFT;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          shreg_d   = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          abort_d   = 1'b0;
          ovf_d     = 1'b0;
        end
      end
      WAIT_SHIFT, CAPTURE: begin
        if (strobe && !scan_load) begin
          final_bit = (bit_cnt_q == bit_cnt_max);
          // bit_cnt stops on the final bit, so a full run ends with bit_cnt == bit_cnt_max
          if (!final_bit && bit_cnt_q != 10'h3ff) begin
            bit_cnt_d = bit_cnt_q + 10'd1;
          end
          if (final_bit || bit_idx_q == IDX_W'(WORD_W - 1)) begin
            word_load = 1'b1;
            new_word  = capt_word;
            shreg_d   = '0;
            bit_idx_d = '0;
          end else begin
            shreg_d   = capt_word;
            bit_idx_d = bit_idx_q + 1'b1;
          end
          if (final_bit) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = CAPTURE;
          end
        end else if (strobe && state_q == CAPTURE) begin
          state_d = DONE;
          abort_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          // An abort exactly on a word boundary has nothing left to flush
          if (bit_idx_q != '0) begin
            word_load = 1'b1;
            new_word  = shreg_q;
          end
          shreg_d   = '0;
          bit_idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_load) begin
      if (word_valid_q && !word_if.word_ready) begin
        ovf_d = 1'b1;
      end else begin
        word_data_d  = new_word;
        word_valid_d = 1'b1;
      end
    end

    if (!enable) begin
      state_d      = IDLE;
      sync_d       = '0;
      bit_cnt_d    = '0;
      bit_idx_d    = '0;
      shreg_d      = '0;
      word_data_d  = '0;
      word_valid_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      abort_d      = 1'b0;
      ovf_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      ovf_q        <= ovf_d;
    end
  end

  assign word_if.word_data  = word_data_q;
  assign word_if.word_valid = word_valid_q;
  assign bit_cnt            = bit_cnt_q;
  assign status_busy        = busy_q;
  assign status_done        = done_q;
  assign status_abort       = abort_q;
  assign status_overflow    = ovf_q;
  assign state              = state_q;

endmodule

// File: tb/tb_ip2_scan_out_capture.sv
// Bench for ip2_scan_out_capture: directed scenarios plus randomized runs,
// checked every cycle against a bit-queue reference model.
module tb_ip2_scan_out_capture;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset_not, enable, test_start_re, scan_load, scan_out;
  logic [5:0] clk_counter, test_sample_phase;
  logic [9:0] bit_cnt_max, bit_cnt;
  logic       status_busy, status_done, status_abort, status_overflow;
  logic [1:0] state;

  always #5 clk = ~clk;

  ip2_scan_out_capture_if #(.WORD_W(W)) word_if ();

  ip2_scan_out_capture #(.WORD_W(W), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .reset_not         (reset_not),
    .enable            (enable),
    .clk_counter       (clk_counter),
    .test_sample_phase (test_sample_phase),
    .test_start_re     (test_start_re),
    .scan_load         (scan_load),
    .scan_out          (scan_out),
    .bit_cnt_max       (bit_cnt_max),
    .word_if           (word_if),
    .bit_cnt           (bit_cnt),
    .status_busy       (status_busy),
    .status_done       (status_done),
    .status_abort      (status_abort),
    .status_overflow   (status_overflow),
    .state             (state)
  );

  int checks = 0;
  int errors = 0;
  int ready_mode;

  // Reference model: run phase, captured-bit count, bits of the word in progress.
  int          m_st;
  int          m_cnt;
  bit          m_bits[$];
  logic [31:0] m_dat;
  bit          m_vld, m_busy, m_done, m_abort, m_ovf;
  logic [31:0] acc_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input bit b[$]);
    logic [31:0] w = '0;
    foreach (b[i]) w[i] = b[i];
    return w;
  endfunction

  task automatic model_clear();
    m_st = 0; m_cnt = 0; m_bits.delete(); m_dat = '0;
    m_vld = 0; m_busy = 0; m_done = 0; m_abort = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit          strobe, xfer, load, fin;
    logic [31:0] nw;
    strobe = (clk_counter == test_sample_phase);
    xfer   = m_vld && word_if.word_ready;
    load   = 0;
    nw     = '0;
    if (!enable) begin
      model_clear();
      return;
    end
    if (xfer) acc_words.push_back(m_dat);
    if (m_st == 0 || m_st == 3) begin
      if (test_start_re) begin
        m_st = 1; m_cnt = 0; m_bits.delete();
        m_busy = 1; m_done = 0; m_abort = 0; m_ovf = 0;
      end
    end else if (strobe) begin
      if (!scan_load) begin
        m_bits.push_back(scan_out);
        fin = (m_cnt == int'(bit_cnt_max));
        if (!fin) m_cnt++;
        if (fin || m_bits.size() == W) begin
          load = 1; nw = pack(m_bits); m_bits.delete();
        end
        if (fin) begin m_st = 3; m_done = 1; m_busy = 0; end
        else m_st = 2;
      end else if (m_st == 2) begin
        m_st = 3; m_abort = 1; m_done = 1; m_busy = 0;
        if (m_bits.size() > 0) begin
          load = 1; nw = pack(m_bits); m_bits.delete();
        end
      end
    end
    if (load && m_vld && !word_if.word_ready) m_ovf = 1;
    else if (load) begin m_dat = nw; m_vld = 1; end
    else if (xfer) m_vld = 0;
  endtask

  task automatic compare();
    check("state", 32'(state), m_st);
    check("bit_cnt", 32'(bit_cnt), m_cnt);
    check("word_valid", 32'(word_if.word_valid), 32'(m_vld));
    if (m_vld) check("word_data", word_if.word_data, m_dat);
    check("status_busy", 32'(status_busy), 32'(m_busy));
    check("status_done", 32'(status_done), 32'(m_done));
    check("status_abort", 32'(status_abort), 32'(m_abort));
    check("status_overflow", 32'(status_overflow), 32'(m_ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
    check({tag, "_valid"}, 32'(word_if.word_valid), 0);
    check({tag, "_data"}, word_if.word_data, 0);
    check({tag, "_flags"}, {28'd0, status_busy, status_done, status_abort, status_overflow}, 0);
  endtask

  task automatic tick();
    case (ready_mode)
      0:       word_if.word_ready = 1'b0;
      1:       word_if.word_ready = 1'b1;
      default: word_if.word_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    clk_counter = clk_counter + 6'd1;
  endtask

  // One slow-clock period (64 clk); scan_load/scan_out change at counter 0.
  task automatic period(input bit sl, input bit so, input int start_at, input int en_off_at);
    scan_load = sl;
    scan_out  = so;
    for (int i = 0; i < 64; i++) begin
      test_start_re = (i == start_at);
      enable        = (i != en_off_at);
      tick();
    end
    test_start_re = 1'b0;
    enable        = 1'b1;
  endtask

  initial begin
    logic [7:0] a5;
    int         n_ok;
    a5 = 8'hA5;
    reset_not = 1'b0; enable = 1'b1; test_start_re = 1'b0;
    scan_load = 1'b1; scan_out = 1'b0; clk_counter = '0;
    test_sample_phase = 6'd10; bit_cnt_max = '0;
    word_if.word_ready = 1'b0; ready_mode = 1;
    model_clear();
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset_not = 1'b1;

    // 768-bit 0xA5 pattern
    acc_words.delete();
    bit_cnt_max = 10'd767;
    for (int i = 0; i < 768; i++) period(1'b0, a5[i % 8], (i == 0) ? 0 : -1, -1);
    period(1'b1, 1'b0, -1, -1);
    check("t1_words", acc_words.size(), 24);
    n_ok = 0;
    foreach (acc_words[i]) if (acc_words[i] == 32'hA5A5A5A5) n_ok++;
    check("t1_words_a5", n_ok, 24);
    check("t1_flags", {m_done, m_abort, m_ovf}, 3'b100);
    check("t1_bit_cnt", m_cnt, 767);

    // 40 ones
    acc_words.delete();
    bit_cnt_max = 10'd39;
    for (int i = 0; i < 40; i++) period(1'b0, 1'b1, (i == 0) ? 0 : -1, -1);
    period(1'b1, 1'b0, -1, -1);
    check("t2_words", acc_words.size(), 2);
    check("t2_word0", acc_words[0], 32'hFFFFFFFF);
    check("t2_word1", acc_words[1], 32'h000000FF);
    check("t2_state", m_st, 3);

    // scan_load high for 5 strobes, 10 bits, then abort
    acc_words.delete();
    bit_cnt_max = 10'd767;
    for (int i = 0; i < 5; i++) period(1'b1, 1'b0, (i == 0) ? 0 : -1, -1);
    for (int i = 0; i < 10; i++) period(1'b0, 1'b1, -1, -1);
    period(1'b1, 1'b1, -1, -1);
    period(1'b1, 1'b0, -1, -1);
    check("t3_words", acc_words.size(), 1);
    check("t3_word0", acc_words[0], 32'h000003FF);
    check("t3_flags", {m_done, m_abort}, 2'b11);
    check("t3_bit_cnt", m_cnt, 10);

    // consumer stalled across a 64-bit run
    acc_words.delete();
    ready_mode = 0;
    bit_cnt_max = 10'd63;
    for (int i = 0; i < 64; i++) period(1'b0, (i < 32) ? 1'(i & 1) : 1'b1, (i == 0) ? 0 : -1, -1);
    check("t4_none_yet", acc_words.size(), 0);
    ready_mode = 1;
    period(1'b1, 1'b0, -1, -1);
    check("t4_words", acc_words.size(), 1);
    check("t4_word0", acc_words[0], 32'hAAAAAAAA);
    check("t4_ovf", m_ovf, 1);

    // async reset during bit 17, then fresh run
    bit_cnt_max = 10'd767;
    for (int i = 0; i < 17; i++) period(1'b0, 1'b1, (i == 0) ? 0 : -1, -1);
    scan_load = 1'b0; scan_out = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i == 5) begin
        reset_not = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_clear();
        @(posedge clk); @(negedge clk);
        reset_not = 1'b1;
      end
      tick();
    end
    acc_words.delete();
    bit_cnt_max = 10'd31;
    for (int i = 0; i < 32; i++) period(1'b0, (i % 5) == 0, (i == 0) ? 0 : -1, -1);
    period(1'b1, 1'b0, -1, -1);
    check("t5_words", acc_words.size(), 1);
    check("t5_word0", acc_words[0], 32'h42108421);

    // start ignored while busy; enable dropped mid-run
    bit_cnt_max = 10'd767;
    for (int i = 0; i < 6; i++) period(1'b0, 1'b1, (i == 0) ? 0 : -1, -1);
    period(1'b0, 1'b1, 20, -1);
    check("t6_state_busy", m_st, 2);
    check("t6_cnt_busy", m_cnt, 7);
    period(1'b0, 1'b1, -1, 30);
    check("t6_state_en", m_st, 0);
    check("t6_cnt_en", m_cnt, 0);
    period(1'b1, 1'b0, -1, -1);

    // single-bit run
    acc_words.delete();
    bit_cnt_max = 10'd0;
    period(1'b0, 1'b1, 0, -1);
    period(1'b1, 1'b0, -1, -1);
    check("t7_words", acc_words.size(), 1);
    check("t7_word0", acc_words[0], 32'h00000001);
    check("t7_done", m_done, 1);

    // randomized runs
    for (int r = 0; r < 5; r++) begin
      test_sample_phase = 6'($urandom_range(3, 63));
      bit_cnt_max       = 10'($urandom_range(0, 40));
      ready_mode        = 2;
      for (int p = 0; p < int'(bit_cnt_max) + 3; p++) begin
        period($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
               (p == 0) ? 0 : (($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : -1),
               -1);
      end
      ready_mode = 1;
      period(1'b1, 1'b0, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip2_scan_out_capture.md
# ip2_scan_out_capture

Receive-side companion to the scan-chain shift-in test sequencer: captures the ASIC `scan_out` serial stream while the scan chain is in shift-register mode (`scan_load`=0), packs bits into WORD_W-bit words and hands them to the readout FIFO over a valid/ready handshake. Sits in the pl_clk1 (400 MHz) fabric domain alongside the test state machines and samples once per slow-clock period at a software-programmable phase of the shared `clk_counter`.

## Interface
- WORD_W, 32, packed word width; must be a power of two, ≤32
- SYNC_STAGES, 2, flops in the `scan_out` synchronizer (≥2)

- clk  in  1  FM clock 400 MHz (pl_clk1)
- reset_not  in  1  asynchronous, active-low reset
- enable  in  1  block enable; low = synchronous return to IDLE, same values as reset
- clk_counter  in  6  shared slow-period phase counter
- test_sample_phase  in  6  `clk_counter` value at which a bit is sampled (strobe)
- test_start_re  in  1  single-cycle start pulse
- scan_load  in  1  scan-chain mode driven to the ASIC: 0 = shift register, 1 = parallel load
- scan_out  in  1  ASIC scan-chain serial output (asynchronous)
- bit_cnt_max  in  10  bits to capture minus one (767 → 768 bits)
- word_ready  in  1  downstream accepts `word_data`
- word_data  out  WORD_W  packed word, first-captured bit in bit 0
- word_valid  out  1  `word_data` valid
- bit_cnt  out  10  bits captured in current run
- status_busy / status_done / status_abort / status_overflow  out  1 each
- state  out  2  current FSM state

## Operation
- Reset (async) or enable=0: state=IDLE, all outputs 0, internal shift register/bit index cleared, synchronizer flops cleared.
- `scan_out` passes through SYNC_STAGES flops; sampled value is `scan_out_s`.
- Strobe = (clk_counter == test_sample_phase); all captures happen on strobe cycles only.
- States: IDLE=0, WAIT_SHIFT=1, CAPTURE=2, DONE=3.
- IDLE/DONE: test_start_re → WAIT_SHIFT; clear bit_cnt, bit index, status_done/abort/overflow; status_busy=1. Pending word_valid is kept until accepted. test_start_re in WAIT_SHIFT/CAPTURE ignored.
- WAIT_SHIFT: strobes with scan_load=1 ignored; first strobe with scan_load=0 captures bit 0 → CAPTURE.
- CAPTURE: strobe with scan_load=0 captures next bit; strobe with scan_load=1 before completion → status_abort=1, partial word flushed (rule below), → DONE.
- Capture: bit written to position bit_idx (log2(WORD_W) bits, wraps); bit_cnt increments by 1 per captured bit (saturates at 1023).
- Word complete (bit_idx = WORD_W-1) or final bit (bit_cnt == bit_cnt_max at capture) or abort: load word_data with captured bits, unwritten upper bits = 0; assert word_valid; clear shift register.
- Final bit → status_done=1, status_busy=0, → DONE. Abort also sets status_done=1.
- Handshake: transfer on rising edge with word_valid & word_ready; word_data stable while valid & !ready.
- Word load while word_valid=1 and word_ready=0: new word dropped, status_overflow=1 (sticky until next start); existing word kept.
- Word load on same cycle as transfer: old word accepted, new word loaded, word_valid stays 1.
- bit_cnt_max=0: single-bit run, one word with only bit 0 meaningful.

## Timing
- `scan_out` to `scan_out_s` latency = SYNC_STAGES clk; software sets test_sample_phase to absorb this plus ASIC delay.
- Strobe cycle edge: bit captured, bit_cnt updated, word_data/word_valid loaded, state transition — all on that same edge (outputs visible next cycle).
- word_valid deasserts the edge after acceptance unless reloaded same edge.
- One bit per 64 clk max (one strobe per clk_counter period); WORD_W=32 → one word per ≥32 strobes, so a consumer with ready held high never overflows.
- status_* flags registered, held until next test_start_re, reset or enable=0.

## Test plan
- Start, scan_load=0, bit_cnt_max=767, scan_out = 768-bit pattern 0xA5..(repeating) → 24 words, each 0xA5A5A5A5 (bit 0 first), status_done=1, abort=0, overflow=0, bit_cnt=767.
- bit_cnt_max=39, scan_out all ones → word0=0xFFFFFFFF, word1=0x000000FF, then DONE.
- scan_load held 1 for 5 strobes after start then 0 → first 5 strobes ignored, capture begins on 6th; scan_load → 1 after 10 bits of ones → word=0x000003FF, status_abort=1, status_done=1.
- word_ready=0 throughout 64-bit run → word0 held, word1 dropped, status_overflow=1; then ready=1 → word0 transferred once, valid drops.
- reset_not pulsed low mid-CAPTURE (bit 17) → all outputs 0 immediately (async); after release, start → fresh run, first word has bit 0 = first post-restart bit.
- enable=0 for one cycle mid-run → state=IDLE, outputs 0 next edge; test_start_re while busy → no effect on bit_cnt or state.
